divider32_seq: RTL and testbench
================================

// Module: divider32_seq
// PURPOSE
//   Multicycle unsigned restoring divider. It is the subtract-side counterpart of the ripple adder:
//   a shift/subtract datapath that produces one quotient bit per clock.
//   It serves DIVU/REMU in the multicycle processor ALU stage. The control FSM starts it and waits on done.
// PARAMETERS
//   WIDTH      32   operand, quotient and remainder width in bits (>=2)
//   CNT_W      6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous, active-low reset
//   start        in   1      one-cycle request; sampled only when busy==0
//   dividend     in   WIDTH  numerator, captured on accepted start
//   divisor      in   WIDTH  denominator, captured on accepted start
//   busy         out  1      high from the cycle after accept until done
//   done         out  1      one-cycle pulse: quotient/remainder valid
//   quotient     out  WIDTH  result; held stable until next accepted start
//   remainder    out  WIDTH  result; held stable until next accepted start
//   div_by_zero  out  1      set with done when divisor==0; held like results
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE. busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. Counter=0.
//   States:
//     IDLE, start=1 -> divisor==0 ? ZERO : RUN.
//       On accept: latch Q=dividend, D=divisor, R=0, cnt=WIDTH, clear div_by_zero.
//     RUN, each cycle:
//       {R,Q} <<= 1; T = {1'b0,R_shifted} - {1'b0,D}, computed in WIDTH+1 bits.
//       If T[WIDTH]==0: R=T[WIDTH-1:0] and Q[0]=1. Else R unchanged and Q[0]=0.
//       cnt-=1. When cnt reaches 1 on this cycle -> FINISH.
//     ZERO: quotient=all ones, remainder=dividend, div_by_zero=1 -> FINISH.
//     FINISH: done=1 for exactly this cycle; quotient=Q, remainder=R -> IDLE.
//       For the ZERO path, FINISH keeps the values ZERO wrote.
//   Latency: start is sampled at edge k. done is high in cycle k+WIDTH+1 for a nonzero divisor.
//     For divisor==0, done is high in cycle k+2.
//   busy=1 in RUN, ZERO and FINISH; busy=0 in IDLE.
//   start while busy=1 is ignored. It has no side effects and is not queued.
//   The earliest back-to-back start is the cycle after done. That start is accepted in IDLE.
//   Output registers update only on the FINISH transition. Mid-operation they show the previous result.
//   Operand ports may change freely after the accept edge; the internal copies are used.
//   Arithmetic is unsigned only. Invariants: dividend == quotient*divisor + remainder and remainder < divisor.
//     Both hold when div_by_zero==0.
//   Reset asserted mid-RUN aborts at once to the reset values. No done is produced for the aborted operation.
//   The subtract is written as A + ~B + 1, matching the codebase addsub convention. No '/' or '%' operators.
// TESTING
//   100/7: start 1 cycle -> done at k+33, quotient=14, remainder=2, div_by_zero=0.
//   0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0. Also 5/9 -> quotient=0, remainder=5.
//   123/0 -> done at k+2, quotient=0xFFFFFFFF, remainder=123, div_by_zero=1.
//     A following 8/2 clears div_by_zero and gives quotient=4.
//   Start pulse mid-RUN with 50/5 -> ignored; the original 100/7 result is delivered unchanged.
//     Exactly one done pulse.
//   rst_n low at iteration 10 -> all outputs 0 within the same cycle and no done pulse.
//     A fresh 9/3 then gives quotient=3, remainder=0.
//   Random self-check: 1000 operand pairs (edge values 0, 1, 0x80000000, all ones) vs a reference model.
//     Check the invariant on every done.

Source files
------------

// File: rtl/divider32_seq.sv
// -----------------------------------------------------------------------------
// divider32_seq
//
// Multicycle unsigned restoring divider. A shift/subtract datapath retires one
// quotient bit per clock; the multicycle ALU stage starts it for DIVU/REMU and
// waits on done.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous, active-low reset
//   start        in   1      one-cycle request, sampled only while busy==0
//   dividend     in   WIDTH  numerator, captured on accepted start
//   divisor      in   WIDTH  denominator, captured on accepted start
//   busy         out  1      high from the cycle after accept until done
//   done         out  1      one-cycle pulse: quotient/remainder valid
//   quotient     out  WIDTH  result, held until the next completed operation
//   remainder    out  WIDTH  result, held until the next completed operation
//   div_by_zero  out  1      set with done when divisor==0
//
// Timing: start sampled at edge k. Nonzero divisor -> done high in cycle
// k+WIDTH+1. Zero divisor -> done high in cycle k+2.
// CNT_W must satisfy 2**CNT_W > WIDTH so the counter can hold WIDTH.
// -----------------------------------------------------------------------------
module divider32_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        ZERO   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;

    // Working registers. q_work_q starts as the dividend and fills with
    // quotient bits from the right as dividend bits shift out on the left.
    logic [WIDTH-1:0] q_work_q;
    logic [WIDTH-1:0] r_work_q;
    logic [WIDTH-1:0] d_q;

    // Registered outputs
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    // -------------------------------------------------------------------------
    // One restoring iteration.
    // The shifted partial remainder is kept WIDTH+1 bits wide: with a divisor
    // above 2**(WIDTH-1) the partial remainder can have its MSB set, and
    // dropping the bit shifted out of it would corrupt the result. Because the
    // partial remainder is always below the divisor, the shifted value is at
    // most 2*D-1, so a non-negative difference always fits in WIDTH bits and
    // bit WIDTH of the difference is a clean borrow flag.
    // -------------------------------------------------------------------------
    logic [WIDTH:0]   r_wide_d;
    logic [WIDTH:0]   diff_d;
    logic             sub_ok_d;
    logic [WIDTH-1:0] r_iter_d;
    logic [WIDTH-1:0] q_iter_d;

    always_comb begin
        r_wide_d = {r_work_q, q_work_q[WIDTH-1]};
        // Subtract as A + ~B + 1, like the rest of the addsub datapath
        diff_d   = r_wide_d + ~{1'b0, d_q} + {{WIDTH{1'b0}}, 1'b1};
        sub_ok_d = ~diff_d[WIDTH];
        r_iter_d = sub_ok_d ? diff_d[WIDTH-1:0] : r_wide_d[WIDTH-1:0];
        q_iter_d = {q_work_q[WIDTH-2:0], sub_ok_d};
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            q_work_q    <= '0;
            r_work_q    <= '0;
            d_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            // done is a single-cycle pulse unless the FINISH entry below sets it
            done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        q_work_q <= dividend;
                        d_q      <= divisor;
                        r_work_q <= '0;
                        cnt_q    <= CNT_W'(WIDTH);
                        dbz_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= (divisor == '0) ? ZERO : RUN;
                    end
                end

                RUN: begin
                    q_work_q <= q_iter_d;
                    r_work_q <= r_iter_d;
                    cnt_q    <= cnt_q - CNT_W'(1);
                    // cnt==1 means this is the last of the WIDTH iterations,
                    // so the iteration result goes straight to the outputs.
                    if (cnt_q == CNT_W'(1)) begin
                        quotient_q  <= q_iter_d;
                        remainder_q <= r_iter_d;
                        done_q      <= 1'b1;
                        state_q     <= FINISH;
                    end
                end

                ZERO: begin
                    // q_work_q still holds the untouched dividend here
                    quotient_q  <= '1;
                    remainder_q <= q_work_q;
                    dbz_q       <= 1'b1;
                    done_q      <= 1'b1;
                    state_q     <= FINISH;
                end

                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider32_seq.sv
// -----------------------------------------------------------------------------
// tb_divider32_seq
//
// Self-checking bench for divider32_seq: a directed vector table, hand-written
// sequences for ignored starts and mid-run reset, and 1000 random operand
// pairs checked against a plain-arithmetic reference (/ and %).
// -----------------------------------------------------------------------------
module tb_divider32_seq;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_vec = 0;
    int n_err = 0;

    divider32_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           lat;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: divide by zero yields all ones / dividend, else plain / and %
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output int lat);
        if (b == 0) begin
            q = '1; r = a; z = 1'b1; lat = 2;
        end else begin
            q = a / b; r = a % b; z = 1'b0; lat = W + 1;
        end
    endtask

    // Issue one operation, wait (bounded) for done, return results and the
    // number of falling edges from accept to done (0 = timeout).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z, output int lat);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Operand ports are free to change after the accept edge
        dividend = $urandom; divisor = $urandom;
        lat = 0; q = '0; r = '0; z = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n; q = quotient; r = remainder; z = div_by_zero;
                break;
            end
        end
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'(0));
    endtask

    task automatic check_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r, eq, er;
        logic         z, ez;
        int           lat, elat;
        longint unsigned recon;
        model(a, b, eq, er, ez, elat);
        run_op(a, b, q, r, z, lat);
        check({tag, "_lat"}, 64'(lat), 64'(elat));
        check({tag, "_quot"}, 64'(q), 64'(eq));
        check({tag, "_rem"}, 64'(r), 64'(er));
        check({tag, "_dbz"}, 64'(z), 64'(ez));
        if (!z && lat != 0) begin
            recon = longint'(q) * longint'(b) + longint'(r);
            check({tag, "_invariant"}, 64'(recon), 64'(a));
            check({tag, "_rem_lt_div"}, 64'(r < b), 64'(1));
        end
        $display("%s: %h / %h -> q=%h r=%h dbz=%0d lat=%0d", tag, a, b, q, r, z, lat);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 255));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [W-1:0] q, r;
        logic         z;
        int           lat, dones;

        tbl[0] = '{32'd100,        32'd7,        32'd14,        32'd2,         1'b0, 33};
        tbl[1] = '{32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,         1'b0, 33};
        tbl[2] = '{32'd5,          32'd9,        32'd0,         32'd5,         1'b0, 33};
        tbl[3] = '{32'd123,        32'd0,        32'hFFFF_FFFF, 32'd123,       1'b1, 2};
        tbl[4] = '{32'd8,          32'd2,        32'd4,         32'd0,         1'b0, 33};
        tbl[5] = '{32'd0,          32'd5,        32'd0,         32'd0,         1'b0, 33};
        tbl[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,        32'd0,         1'b0, 33};
        tbl[7] = '{32'hFFFF_FFFE,  32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFFE, 1'b0, 33};
        tbl[8] = '{32'hFFFF_FFFF,  32'h8000_0001, 32'd1,        32'h7FFF_FFFE, 1'b0, 33};
        tbl[9] = '{32'd0,          32'd0,        32'hFFFF_FFFF, 32'd0,         1'b1, 2};

        start = 1'b0; dividend = '0; divisor = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_quot", 64'(quotient), 64'(0));
        check("reset_rem", 64'(remainder), 64'(0));
        check("reset_dbz", 64'(div_by_zero), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].a, tbl[i].b, q, r, z, lat);
            check("tbl_lat", 64'(lat), 64'(tbl[i].lat));
            check("tbl_quot", 64'(q), 64'(tbl[i].q));
            check("tbl_rem", 64'(r), 64'(tbl[i].r));
            check("tbl_dbz", 64'(z), 64'(tbl[i].z));
            $display("table[%0d]: %h / %h -> q=%h r=%h dbz=%0d lat=%0d",
                     i, tbl[i].a, tbl[i].b, q, r, z, lat);
        end

        // Establish a known previous result, then start 100/7 and pulse an
        // ignored 50/5 start in the middle of the run.
        check_op("pre_8_2", 32'd8, 32'd2);
        @(negedge clk);
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        dones = 0; lat = 0; q = '0; r = '0; z = 1'b1;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (n == 1) check("busy_after_accept", 64'(busy), 64'(1));
            if (n == 5) begin
                check("held_quot_mid_run", 64'(quotient), 64'(4));
                check("held_rem_mid_run", 64'(remainder), 64'(0));
                start = 1'b1; dividend = 32'd50; divisor = 32'd5;
            end
            if (n == 6) start = 1'b0;
            if (done) begin
                dones++;
                if (dones == 1) begin
                    lat = n; q = quotient; r = remainder; z = div_by_zero;
                end
            end
        end
        check("ignored_start_dones", 64'(dones), 64'(1));
        check("ignored_start_lat", 64'(lat), 64'(33));
        check("ignored_start_quot", 64'(q), 64'(14));
        check("ignored_start_rem", 64'(r), 64'(2));
        check("ignored_start_dbz", 64'(z), 64'(0));
        check("idle_after_run", 64'(busy), 64'(0));
        $display("ignored_start: 100 / 7 -> q=%0d r=%0d dones=%0d lat=%0d", q, r, dones, lat);

        // Reset asserted at iteration 10 of a run
        @(negedge clk);
        start = 1'b1; dividend = 32'd100; divisor = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_quot", 64'(quotient), 64'(0));
        check("abort_rem", 64'(remainder), 64'(0));
        check("abort_dbz", 64'(div_by_zero), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'(0));
        $display("reset_abort: outputs cleared, dones afterwards=%0d", dones);
        check_op("after_abort_9_3", 32'd9, 32'd3);

        // Random operands including edge values
        for (int i = 0; i < 1000; i++) begin
            check_op("rand", pick(), pick());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
